// File: rtl/doppler_scheduler_if.sv
// Datapath-facing bundle of the Doppler measurement scheduler: receiver
// sample strobe in, gated strobe out to the FFT, velocity result in and the
// latched result out.
interface doppler_scheduler_if;
  logic        adc_valid_in;
  logic        sample_valid_out;
  logic        doppler_ready_in;
  logic [15:0] velocity_in;
  logic        towards_in;
  logic [15:0] velocity_out;
  logic        towards_out;
  logic        result_valid_out;

  // Scheduler side: consumes receiver/velocity strobes, drives gated samples and results.
  modport master (
    input  adc_valid_in,
    input  doppler_ready_in,
    input  velocity_in,
    input  towards_in,
    output sample_valid_out,
    output velocity_out,
    output towards_out,
    output result_valid_out
  );

  // Datapath side: produces receiver/velocity strobes, observes gated samples and results.
  modport slave (
    output adc_valid_in,
    output doppler_ready_in,
    output velocity_in,
    output towards_in,
    input  sample_valid_out,
    input  velocity_out,
    input  towards_out,
    input  result_valid_out
  );
endinterface

// File: rtl/doppler_scheduler.sv
// Doppler radar measurement scheduler. Sequences one measurement as
// transmit burst -> settle dead time -> sample capture -> wait for the
// velocity result -> hold-off until the measurement period has elapsed,
// optionally repeating while continuous_in is high. abort_in cancels at
// once; tx_en_out and sample_valid_out are gated by it combinationally.
module doppler_scheduler #(
  parameter int BURST_CYCLES   = 400,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int FFT_SIZE       = 2048,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int PERIOD_CYCLES  = 1000000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic                   continuous_in,
  input  logic                   abort_in,
  doppler_scheduler_if.master    dp,
  output logic                   tx_en_out,
  output logic                   timeout_out,
  output logic                   busy_out
);

  localparam int BW = $clog2(BURST_CYCLES) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int FW = $clog2(FFT_SIZE) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PW = $clog2(PERIOD_CYCLES) + 1;

  localparam logic [BW-1:0] BURST_LAST   = BW'(BURST_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0] SAMPLE_LAST  = FW'(FFT_SIZE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_BURST       = 3'd1,
    S_SETTLE      = 3'd2,
    S_CAPTURE     = 3'd3,
    S_WAIT_RESULT = 3'd4,
    S_HOLDOFF     = 3'd5
  } state_t;

  state_t          state_r;
  logic [BW-1:0]   burst_cnt_r;
  logic [SW-1:0]   settle_cnt_r;
  logic [FW-1:0]   sample_cnt_r;
  logic [TW-1:0]   timeout_cnt_r;
  logic [PW-1:0]   period_cnt_r;
  logic            tx_en_r;
  logic            busy_r;
  logic            timeout_r;
  logic            result_valid_r;
  logic [15:0]     velocity_r;
  logic            towards_r;
  logic            capture_s;

  // Measurement sequencer: state, phase counters and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r        <= S_IDLE;
      burst_cnt_r    <= '0;
      settle_cnt_r   <= '0;
      sample_cnt_r   <= '0;
      timeout_cnt_r  <= '0;
      period_cnt_r   <= '0;
      tx_en_r        <= 1'b0;
      busy_r         <= 1'b0;
      timeout_r      <= 1'b0;
      result_valid_r <= 1'b0;
      velocity_r     <= 16'h0000;
      towards_r      <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      if (abort_in) begin
        // Abort wins over every other event in the same cycle.
        state_r       <= S_IDLE;
        burst_cnt_r   <= '0;
        settle_cnt_r  <= '0;
        sample_cnt_r  <= '0;
        timeout_cnt_r <= '0;
        period_cnt_r  <= '0;
        tx_en_r       <= 1'b0;
        busy_r        <= 1'b0;
      end else begin
        // The period counter runs through the whole measurement and saturates,
        // so a period shorter than the measurement leaves a one-cycle hold-off.
        if ((state_r != S_IDLE) && (period_cnt_r != PERIOD_LAST)) begin
          period_cnt_r <= period_cnt_r + PW'(1);
        end
        case (state_r)
          S_IDLE: begin
            if (start_in || continuous_in) begin
              state_r      <= S_BURST;
              tx_en_r      <= 1'b1;
              busy_r       <= 1'b1;
              timeout_r    <= 1'b0;
              period_cnt_r <= '0;
              burst_cnt_r  <= '0;
              settle_cnt_r <= '0;
              sample_cnt_r <= '0;
              timeout_cnt_r <= '0;
            end
          end
          S_BURST: begin
            if (burst_cnt_r == BURST_LAST) begin
              state_r     <= S_SETTLE;
              tx_en_r     <= 1'b0;
              burst_cnt_r <= '0;
            end else begin
              burst_cnt_r <= burst_cnt_r + BW'(1);
            end
          end
          S_SETTLE: begin
            if (settle_cnt_r == SETTLE_LAST) begin
              state_r      <= S_CAPTURE;
              settle_cnt_r <= '0;
            end else begin
              settle_cnt_r <= settle_cnt_r + SW'(1);
            end
          end
          S_CAPTURE: begin
            if (dp.adc_valid_in) begin
              if (sample_cnt_r == SAMPLE_LAST) begin
                state_r      <= S_WAIT_RESULT;
                sample_cnt_r <= '0;
              end else begin
                sample_cnt_r <= sample_cnt_r + FW'(1);
              end
            end
          end
          S_WAIT_RESULT: begin
            if (dp.doppler_ready_in) begin
              velocity_r     <= dp.velocity_in;
              towards_r      <= dp.towards_in;
              result_valid_r <= 1'b1;
              timeout_cnt_r  <= '0;
              state_r        <= S_HOLDOFF;
            end else if (timeout_cnt_r == TIMEOUT_LAST) begin
              timeout_r     <= 1'b1;
              timeout_cnt_r <= '0;
              state_r       <= S_HOLDOFF;
            end else begin
              timeout_cnt_r <= timeout_cnt_r + TW'(1);
            end
          end
          S_HOLDOFF: begin
            if (period_cnt_r >= PERIOD_LAST) begin
              if (continuous_in) begin
                state_r       <= S_BURST;
                tx_en_r       <= 1'b1;
                busy_r        <= 1'b1;
                timeout_r     <= 1'b0;
                period_cnt_r  <= '0;
                burst_cnt_r   <= '0;
                settle_cnt_r  <= '0;
                sample_cnt_r  <= '0;
                timeout_cnt_r <= '0;
              end else begin
                state_r      <= S_IDLE;
                busy_r       <= 1'b0;
                period_cnt_r <= '0;
              end
            end
          end
          default: begin
            state_r      <= S_IDLE;
            tx_en_r      <= 1'b0;
            busy_r       <= 1'b0;
            period_cnt_r <= '0;
          end
        endcase
      end
    end
  end

  assign capture_s = (state_r == S_CAPTURE);

  // Abort must silence the transmitter and the FFT strobe in the same cycle.
  assign tx_en_out            = tx_en_r & ~abort_in;
  assign dp.sample_valid_out  = dp.adc_valid_in & capture_s & ~abort_in;
  assign dp.velocity_out      = velocity_r;
  assign dp.towards_out       = towards_r;
  assign dp.result_valid_out  = result_valid_r;
  assign timeout_out          = timeout_r;
  assign busy_out             = busy_r;

endmodule

// File: tb/tb_doppler_scheduler.sv
// Directed bench for doppler_scheduler with small parameters: single shot,
// timeout, continuous repetition, abort in capture and reset in burst.
// Expected results go into a scoreboard queue when the velocity strobe is
// driven and are checked when the result pulse appears.
module tb_doppler_scheduler;
  localparam int BURST   = 4;
  localparam int SETTLE  = 3;
  localparam int FFT     = 8;
  localparam int TMO     = 20;
  localparam int PERIOD  = 60;

  typedef struct {
    logic [15:0] vel;
    logic        tow;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic cont;
  logic abort;
  logic tx_en;
  logic timeout;
  logic busy;
  logic adc_gen;

  doppler_scheduler_if dp ();

  doppler_scheduler #(
    .BURST_CYCLES   (BURST),
    .SETTLE_CYCLES  (SETTLE),
    .FFT_SIZE       (FFT),
    .TIMEOUT_CYCLES (TMO),
    .PERIOD_CYCLES  (PERIOD)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .continuous_in (cont),
    .abort_in      (abort),
    .dp            (dp),
    .tx_en_out     (tx_en),
    .timeout_out   (timeout),
    .busy_out      (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tx_cycles;
  int sv_pulses;
  int res_cycles;
  int busy_fall_cyc;
  int to_rise_cyc;
  int res_cyc;
  int rdy_cyc;
  int e_cyc;
  int tx_rise_q[$];
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    tx_cycles     = 0;
    sv_pulses     = 0;
    res_cycles    = 0;
    busy_fall_cyc = -1;
    to_rise_cyc   = -1;
    res_cyc       = -1;
    tx_rise_q.delete();
  endtask

  task automatic wait_samples(input string tag, input int target, input int lim);
    int n = 0;
    while (sv_pulses < target && n < lim) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_sample_bound"}, 32'(sv_pulses >= target), 32'd1);
  endtask

  task automatic wait_busy_fall(input string tag, input int lim);
    int n = 0;
    while (busy_fall_cyc < 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_idle_bound"}, 32'(busy_fall_cyc >= 0), 32'd1);
  endtask

  task automatic wait_tx_rises(input string tag, input int target, input int lim);
    int n = 0;
    while (tx_rise_q.size() < target && n < lim) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_burst_bound"}, 32'(tx_rise_q.size() >= target), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (adc_gen) dp.adc_valid_in = ~dp.adc_valid_in;
    end
  end

  initial begin : monitor
    logic ptx;
    logic pbusy;
    logic pto;
    exp_t e;
    ptx = 1'b0;
    pbusy = 1'b0;
    pto = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en) tx_cycles++;
      if (tx_en && !ptx) tx_rise_q.push_back(cyc);
      if (!busy && pbusy) busy_fall_cyc = cyc;
      if (timeout && !pto) to_rise_cyc = cyc;
      if (dp.sample_valid_out) sv_pulses++;
      if (dp.result_valid_out) begin
        res_cycles++;
        res_cyc = cyc;
        check("sb_expected_present", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("sb_velocity", {16'h0000, dp.velocity_out}, {16'h0000, e.vel});
          check("sb_towards", {31'h0, dp.towards_out}, {31'h0, e.tow});
        end
      end
      ptx = tx_en;
      pbusy = busy;
      pto = timeout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    abort = 1'b0;
    adc_gen = 1'b0;
    dp.adc_valid_in     = 1'b0;
    dp.doppler_ready_in = 1'b0;
    dp.velocity_in      = 16'h0000;
    dp.towards_in       = 1'b0;
    clear_stats();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", {31'h0, tx_en}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_timeout", {31'h0, timeout}, 32'd0);
    check("rst_velocity", {16'h0, dp.velocity_out}, 32'd0);
    check("rst_towards", {31'h0, dp.towards_out}, 32'd0);
    check("rst_result", {31'h0, dp.result_valid_out}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", {31'h0, busy}, 32'd0);

    // Single shot with a result five cycles into the result wait
    clear_stats();
    adc_gen = 1'b1;
    pulse_start();
    check("t1_tx_on", {31'h0, tx_en}, 32'd1);
    check("t1_busy_on", {31'h0, busy}, 32'd1);
    wait_samples("t1", FFT, 100);
    repeat (4) @(posedge clk);
    #1;
    dp.doppler_ready_in = 1'b1;
    dp.velocity_in      = 16'h0123;
    dp.towards_in       = 1'b1;
    sb_q.push_back('{vel: 16'h0123, tow: 1'b1});
    rdy_cyc = cyc;
    @(posedge clk);
    #1;
    dp.doppler_ready_in = 1'b0;
    dp.velocity_in      = 16'hFFFF;
    dp.towards_in       = 1'b0;
    wait_busy_fall("t1", 100);
    #1;
    check("t1_tx_cycles", 32'(tx_cycles), 32'(BURST));
    check("t1_samples", 32'(sv_pulses), 32'(FFT));
    check("t1_result_pulses", 32'(res_cycles), 32'd1);
    check("t1_result_latency", 32'(res_cyc - rdy_cyc), 32'd1);
    check("t1_velocity", {16'h0, dp.velocity_out}, 32'h0123);
    check("t1_towards", {31'h0, dp.towards_out}, 32'd1);
    check("t1_timeout", {31'h0, timeout}, 32'd0);
    check("t1_period_exit", 32'(busy_fall_cyc - tx_rise_q[0]), 32'(PERIOD));
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Timeout without a velocity result
    clear_stats();
    pulse_start();
    wait_samples("t2", FFT, 100);
    #1;
    e_cyc = cyc;
    wait_busy_fall("t2", 100);
    #1;
    check("t2_timeout_delay", 32'(to_rise_cyc - e_cyc), 32'(TMO));
    check("t2_timeout_sticky", {31'h0, timeout}, 32'd1);
    check("t2_no_result", 32'(res_cycles), 32'd0);
    check("t2_velocity_kept", {16'h0, dp.velocity_out}, 32'h0123);
    check("t2_towards_kept", {31'h0, dp.towards_out}, 32'd1);

    // Continuous: bursts a fixed period apart, timeout cleared by the second burst
    clear_stats();
    cont = 1'b1;
    wait_tx_rises("t3", 2, 200);
    #1;
    check("t3_burst_spacing", 32'(tx_rise_q[1] - tx_rise_q[0]), 32'(PERIOD));
    check("t3_timeout_rose", 32'(to_rise_cyc > tx_rise_q[0]), 32'd1);
    check("t3_timeout_cleared", {31'h0, timeout}, 32'd0);
    cont = 1'b0;
    wait_busy_fall("t3", 200);
    #1;
    check("t3_bursts", 32'(tx_rise_q.size()), 32'd2);
    check("t3_tx_cycles", 32'(tx_cycles), 32'(2 * BURST));

    // Abort beats start in IDLE, then abort during capture after three samples
    clear_stats();
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("t4_abort_beats_start", {31'h0, busy}, 32'd0);
    pulse_start();
    wait_samples("t4", 3, 100);
    adc_gen = 1'b0;
    #1;
    dp.adc_valid_in = 1'b1;
    #1;
    check("t4_sv_before_abort", {31'h0, dp.sample_valid_out}, 32'd1);
    abort = 1'b1;
    #1;
    check("t4_sv_gated", {31'h0, dp.sample_valid_out}, 32'd0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("t4_idle_next", {31'h0, busy}, 32'd0);
    check("t4_sv_idle", {31'h0, dp.sample_valid_out}, 32'd0);
    check("t4_samples", 32'(sv_pulses), 32'd3);
    dp.doppler_ready_in = 1'b1;
    dp.velocity_in      = 16'hBEEF;
    dp.towards_in       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dp.doppler_ready_in = 1'b0;
    dp.adc_valid_in     = 1'b0;
    check("t4_no_result", 32'(res_cycles), 32'd0);
    check("t4_velocity_kept", {16'h0, dp.velocity_out}, 32'h0123);
    check("t4_timeout_cleared", {31'h0, timeout}, 32'd0);

    // Reset during burst with start held through the reset
    clear_stats();
    adc_gen = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t5_in_burst", {31'h0, tx_en}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_tx_off", {31'h0, tx_en}, 32'd0);
    check("t5_busy_off", {31'h0, busy}, 32'd0);
    check("t5_velocity_zero", {16'h0, dp.velocity_out}, 32'd0);
    check("t5_towards_zero", {31'h0, dp.towards_out}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_samples", 32'(sv_pulses), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_restart_tx", {31'h0, tx_en}, 32'd1);
    check("t5_restart_busy", {31'h0, busy}, 32'd1);
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    adc_gen = 1'b0;
    check("t5_abort_idle", {31'h0, busy}, 32'd0);
    check("t5_no_result", 32'(res_cycles), 32'd0);
    check("t5_no_samples_end", 32'(sv_pulses), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/doppler_scheduler.md
DOPPLER_SCHEDULER -- requirements
Module: doppler_scheduler

Interface
REQ-001 SHALL have parameter BURST_CYCLES, default 400, transmit burst length in clocks.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1000, dead time after burst before capture, in clocks.
REQ-003 SHALL have parameter FFT_SIZE, default 2048, number of receiver samples forwarded per measurement.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 200000, maximum clocks to wait for a velocity result.
REQ-005 SHALL have parameter PERIOD_CYCLES, default 1000000, minimum clocks between consecutive burst starts in continuous mode.
REQ-006 SHALL have port clk_in, input, 1, the single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_in, input, 1, synchronous active-low reset.
REQ-008 SHALL have port start_in, input, 1, single-measurement request, sampled in IDLE only.
REQ-009 SHALL have port continuous_in, input, 1, repeat measurements while high.
REQ-010 SHALL have port abort_in, input, 1, cancel the current measurement.
REQ-011 SHALL have port adc_valid_in, input, 1, receiver sample strobe.
REQ-012 SHALL have port doppler_ready_in, input, 1, velocity datapath result strobe.
REQ-013 SHALL have ports velocity_in (input, 16, speed magnitude) and towards_in (input, 1, direction).
REQ-014 SHALL have port tx_en_out, output, 1, transmitter enable.
REQ-015 SHALL have port sample_valid_out, output, 1, gated sample strobe to the FFT datapath.
REQ-016 SHALL have ports velocity_out (output, 16) and towards_out (output, 1), latched result.
REQ-017 SHALL have ports result_valid_out (output, 1, one-cycle pulse), timeout_out (output, 1, sticky), busy_out (output, 1).

Function
REQ-018 SHALL implement states IDLE, BURST, SETTLE, CAPTURE, WAIT_RESULT, HOLDOFF.
REQ-019 IDLE: start_in or continuous_in high -> BURST next cycle; busy_out low only in IDLE.
REQ-020 BURST: tx_en_out high for exactly BURST_CYCLES clocks, then SETTLE; tx_en_out low in all other states.
REQ-021 SETTLE: remain exactly SETTLE_CYCLES clocks, then CAPTURE; adc_valid_in ignored.
REQ-022 CAPTURE: sample_valid_out = adc_valid_in combinationally; count forwarded samples; after FFT_SIZE-th forwarded sample go to WAIT_RESULT; sample_valid_out is 0 in all other states.
REQ-023 WAIT_RESULT: on doppler_ready_in latch velocity_in/towards_in into velocity_out/towards_out, pulse result_valid_out one cycle after the strobe, go to HOLDOFF.
REQ-024 WAIT_RESULT: if TIMEOUT_CYCLES clocks elapse without doppler_ready_in, set timeout_out, keep old velocity_out, no result pulse, go to HOLDOFF.
REQ-025 doppler_ready_in in any state other than WAIT_RESULT SHALL be ignored.
REQ-026 Period counter SHALL start at 0 on BURST entry and count every clock; HOLDOFF exits when count reaches PERIOD_CYCLES-1: to BURST if continuous_in high, else IDLE.
REQ-027 If PERIOD_CYCLES is shorter than the measurement, HOLDOFF SHALL last exactly one cycle.
REQ-028 abort_in high in any non-IDLE state SHALL force IDLE next cycle, clear all counters, drop tx_en_out/sample_valid_out immediately (combinational gate), no result pulse.
REQ-029 abort_in has priority over doppler_ready_in and start_in in the same cycle.
REQ-030 timeout_out SHALL clear on the next BURST entry.
REQ-031 Counters SHALL be sized by $clog2 of their parameter +1 and never wrap.

Reset
REQ-032 rst_in low on a clock edge SHALL force IDLE, clear all counters, and drive tx_en_out, sample_valid_out, result_valid_out, timeout_out, busy_out, towards_out low and velocity_out to 0.
REQ-033 Reset mid-measurement SHALL behave as REQ-032 with no result pulse; a held start_in after release begins a new BURST.

Verification (BURST_CYCLES=4, SETTLE_CYCLES=3, FFT_SIZE=8, TIMEOUT_CYCLES=20, PERIOD_CYCLES=60)
REQ-034 Single shot: start_in pulse, adc_valid_in every 2nd cycle, doppler_ready_in 5 cycles into WAIT_RESULT with velocity_in=0x0123, towards_in=1 -> tx_en_out high 4 cycles, exactly 8 sample_valid_out pulses, result_valid_out one pulse, velocity_out=0x0123, towards_out=1, return to IDLE at period count 59.
REQ-035 Timeout: as REQ-034 with no doppler_ready_in -> timeout_out rises 20 cycles after WAIT_RESULT entry, velocity_out unchanged, no result pulse.
REQ-036 Continuous: continuous_in held high -> successive tx_en_out rising edges exactly 60 cycles apart; timeout_out clears at second burst.
REQ-037 Abort during CAPTURE after 3 samples -> sample_valid_out low same cycle, IDLE next cycle, no result pulse; late doppler_ready_in ignored.
REQ-038 Reset low during BURST -> tx_en_out low next edge, all outputs at reset values; strobes in SETTLE/IDLE never reach sample_valid_out.
